mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Downstream consumer of the 8x8 signed radix-4 Booth multiplier; accepts its 16-bit two's-complement product and keeps a running signed sum (multiply-accumulate).
- Saturates on signed overflow and counts accepted products.
- Streams a snapshot of the sum out byte-serially, LSB first, so it fits the 8-bit tile output pins.

Parameters:
- PROD_W, 16, product width; products are signed two's complement.
- ACC_W, 24, accumulator width; must be a multiple of 8 and greater than PROD_W.
- CNT_W, 8, width of the accepted-product counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- prod_in  in  PROD_W  signed product from the multiplier.
- prod_valid  in  1  prod_in is accepted this cycle; always ready, no backpressure.
- acc_clear  in  1  clear the accumulator, counter and overflow flag.
- rd_start  in  1  request a byte-serial readout; honoured only when rd_busy=0.
- rd_data  out  8  readout byte.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_last  out  1  final byte of the readout.
- rd_busy  out  1  readout in progress.
- acc_ovf  out  1  sticky saturation flag.
- acc_count  out  CNT_W  number of accepted products; saturates.
- acc_value  out  ACC_W  live accumulator register.

Behaviour:
- Reset: on a rst edge, acc_value=0, acc_count=0, acc_ovf=0, rd_data=0, rd_valid=0, rd_last=0, rd_busy=0, FSM=IDLE. Applies mid-readout too: the stream aborts with no further rd_valid.
- Accumulate: on prod_valid, acc <= acc + sext(prod_in).
  - Result visible on acc_value one cycle later.
- Overflow detect: operand signs equal and sum sign differs.
  - On overflow, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - acc_ovf sets and stays set until acc_clear or rst.
- Counter: acc_count increments on each accepted product and holds at 2^CNT_W-1.
- acc_clear without prod_valid: acc=0, count=0, ovf=0.
- acc_clear with prod_valid in the same cycle: acc=sext(prod_in), count=1, ovf=0; clear takes priority, then the product is loaded.
- Readout FSM states: IDLE, BYTE[0..ACC_W/8-1].
  - IDLE to BYTE0 when rd_start=1. In the same edge a snapshot register captures the pre-update acc_value; a product accepted in that cycle is excluded.
  - BYTEk drives rd_data=snap[8k+7:8k] with rd_valid=1.
  - BYTEk to BYTEk+1. The last BYTE asserts rd_last=1 and returns to IDLE.
  - Registered outputs: with rd_start at edge N, byte0 appears in cycle N+1 and the last byte in N+ACC_W/8.
  - rd_busy=1 exactly while the FSM is in a BYTE state; rd_start is ignored then.
  - Earliest next start is sampled in the first cycle after rd_last.
- Accumulation continues unaffected during readout; the snapshot is stable.
- In IDLE: rd_data=0, rd_valid=0, rd_last=0.

Decomposition:
- Package mac_pkg holds ACC_W, PROD_W, CNT_W defaults, NBYTES=ACC_W/8, the rd_state_t enum, and a function sat_add(acc, sext_prod) that returns {ovf, result}.
- One sub-module, byte_serializer: snapshot register, FSM, and the rd_* outputs, parameterised by NBYTES.
- Accumulate and saturate logic stays in the top level.

Test Plan:
- Basic sum: after rst, products 100, -300, 32767 on consecutive cycles -> acc_value=32567 (0x007F37), acc_count=3, acc_ovf=0.
- Positive saturation: 257 consecutive products of 32767 -> after 256 acc=8388352. The 257th gives acc=8388607 (0x7FFFFF), acc_ovf=1, acc_count=255.
- Negative boundary: 256 products of -32768 -> acc=-8388608 (0x800000), ovf=0. A 257th product -> acc stays 0x800000, ovf=1.
- Clear with product: acc_ovf=1 and acc=0x7FFFFF, then acc_clear=1 with prod_valid=1, prod_in=-5 -> acc=0xFFFFFB, count=1, ovf=0.
- Readout with concurrent accumulate: acc=0x123456, rd_start with prod_valid=1, prod_in=1 in the same cycle.
  - Stream is rd_data 0x56, 0x34, 0x12; rd_last on 0x12; rd_busy high for 3 cycles.
  - acc_value=0x123457 afterwards.
  - A second rd_start during the stream is ignored.
- Reset mid-read: rst asserted while in BYTE1 -> next cycle all outputs 0, FSM=IDLE, no third byte. A later rd_start streams acc=0 as 0x00, 0x00, 0x00.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, readout state type and saturating adder for the MAC accumulator
package mac_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam int NBYTES = ACC_W / 8;

  // One BYTE state; the byte position is carried in a separate index register
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BYTE = 1'b1
  } rd_state_t;

  // Returns {ovf, result}; result is clamped to the signed range when ovf is set
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [ACC_W-1:0] sext_prod);
    logic [ACC_W-1:0] sum;
    logic             ovf;
    sum = acc + sext_prod;
    ovf = (acc[ACC_W-1] == sext_prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    if (ovf) begin
      sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product input, control and readout bundle for the MAC accumulator
interface mac_accumulator_if #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int CNT_W  = mac_pkg::CNT_W
);

  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              acc_clear;
  logic              rd_start;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_busy;
  logic              acc_ovf;
  logic [CNT_W-1:0]  acc_count;
  logic [ACC_W-1:0]  acc_value;

  modport master (
    output prod_in, prod_valid, acc_clear, rd_start,
    input  rd_data, rd_valid, rd_last, rd_busy, acc_ovf, acc_count, acc_value
  );

  modport slave (
    input  prod_in, prod_valid, acc_clear, rd_start,
    output rd_data, rd_valid, rd_last, rd_busy, acc_ovf, acc_count, acc_value
  );

endinterface

// File: rtl/mac_accumulator_byte_serializer.sv
// rtl/mac_accumulator_byte_serializer.sv - snapshot register and LSB-first byte readout FSM
module byte_serializer
  import mac_pkg::*;
#(
  parameter int NBYTES = mac_pkg::NBYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] snap_in,
  output logic [7:0]          data,
  output logic                valid,
  output logic                last,
  output logic                busy
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  rd_state_t           state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [8*NBYTES-1:0] snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RD_IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      // Capture only on an accepted start so the sum stays frozen for the whole stream
      if (state == RD_IDLE && start) begin
        snap <= snap_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data      = 8'h00;
    valid     = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      RD_IDLE: begin
        if (start) begin
          state_nxt = RD_BYTE;
          idx_nxt   = '0;
        end
      end
      RD_BYTE: begin
        busy  = 1'b1;
        valid = 1'b1;
        data  = snap[8*idx +: 8];
        if (idx == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = RD_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = RD_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating multiply-accumulate sum with product counter and byte readout
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int CNT_W  = mac_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  mac_accumulator_if.slave   bus
);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [ACC_W-1:0] sext_prod;
  logic [ACC_W-1:0] sum_sat;
  logic             add_ovf;

  always_comb begin
    sext_prod          = {{(ACC_W-PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
    {add_ovf, sum_sat} = sat_add(acc, sext_prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (bus.acc_clear) begin
      // Clear wins, then a same-cycle product becomes the first term of the new sum
      acc   <= bus.prod_valid ? sext_prod : '0;
      count <= bus.prod_valid ? CNT_W'(1) : '0;
      ovf   <= 1'b0;
    end else if (bus.prod_valid) begin
      acc <= sum_sat;
      ovf <= ovf | add_ovf;
      if (count != {CNT_W{1'b1}}) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.acc_value = acc;
  assign bus.acc_count = count;
  assign bus.acc_ovf   = ovf;

  byte_serializer #(
    .NBYTES(ACC_W / 8)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (bus.rd_start),
    .snap_in(acc),
    .data   (bus.rd_data),
    .valid  (bus.rd_valid),
    .last   (bus.rd_last),
    .busy   (bus.rd_busy)
  );

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed table and sequence checks for mac_accumulator
module tb_mac_accumulator;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mac_accumulator_if bus ();

  mac_accumulator dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [15:0] prod;
    logic        clr;
    logic [23:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [15:0] prod, input logic clr, input logic st);
    bus.prod_valid = pv;
    bus.prod_in    = prod;
    bus.acc_clear  = clr;
    bus.rd_start   = st;
  endtask

  task automatic chk_acc(input string name, input logic [23:0] a, input logic [7:0] c, input logic o);
    chk({name, ".acc"}, 32'(bus.acc_value), 32'(a));
    chk({name, ".cnt"}, 32'(bus.acc_count), 32'(c));
    chk({name, ".ovf"}, 32'(bus.acc_ovf), 32'(o));
  endtask

  task automatic chk_rd(input string name, input logic [7:0] d, input logic v, input logic l, input logic b);
    chk({name, ".data"}, 32'(bus.rd_data), 32'(d));
    chk({name, ".valid"}, 32'(bus.rd_valid), 32'(v));
    chk({name, ".last"}, 32'(bus.rd_last), 32'(l));
    chk({name, ".busy"}, 32'(bus.rd_busy), 32'(b));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b1, 16'd100,  1'b0, 24'h000064, 8'd1, 1'b0};
    vecs[1] = '{1'b1, 16'hFED4, 1'b0, 24'hFFFF38, 8'd2, 1'b0};
    vecs[2] = '{1'b1, 16'h7FFF, 1'b0, 24'h007F37, 8'd3, 1'b0};
    vecs[3] = '{1'b0, 16'h1234, 1'b0, 24'h007F37, 8'd3, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 24'h000000, 8'd0, 1'b0};
    vecs[5] = '{1'b1, 16'hFFF9, 1'b1, 24'hFFFFF9, 8'd1, 1'b0};
    vecs[6] = '{1'b1, 16'h8000, 1'b0, 24'hFF7FF9, 8'd2, 1'b0};
    vecs[7] = '{1'b1, 16'h7FFF, 1'b0, 24'hFFFFF8, 8'd3, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 24'h000000, 8'd0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk_acc("reset", 24'h0, 8'd0, 1'b0);
    chk_rd("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pv, vecs[i].prod, vecs[i].clr, 1'b0);
      tick();
      chk_acc($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Positive saturation: 256 x 32767 stays in range, the 257th clamps
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 16'h7FFF, 1'b0, 1'b0);
      tick();
    end
    chk_acc("pos256", 24'h7FFF00, 8'd255, 1'b0);
    tick();
    chk_acc("pos257", 24'h7FFFFF, 8'd255, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_acc("pos_hold", 24'h7FFFFF, 8'd255, 1'b1);

    drive(1'b1, 16'hFFFB, 1'b1, 1'b0);
    tick();
    chk_acc("clr_prod", 24'hFFFFFB, 8'd1, 1'b0);

    // Negative boundary: exactly reaches the minimum without overflow
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 16'h8000, 1'b0, 1'b0);
      tick();
    end
    chk_acc("neg256", 24'h800000, 8'd255, 1'b0);
    tick();
    chk_acc("neg257", 24'h800000, 8'd255, 1'b1);

    // Build 0x123456 = 0x347A + 36 * 0x7FFF
    drive(1'b1, 16'h347A, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, 16'h7FFF, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_acc("build", 24'h123456, 8'd37, 1'b0);
    chk_rd("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Readout with a same-cycle product and a held rd_start that must be ignored
    drive(1'b1, 16'h0001, 1'b0, 1'b1);
    tick();
    chk_rd("rd_b0", 8'h56, 1'b1, 1'b0, 1'b1);
    chk("rd_acc", 32'(bus.acc_value), 32'h123457);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    chk_rd("rd_b1", 8'h34, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rd("rd_b2", 8'h12, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_rd("rd_done", 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset while streaming byte 1
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    chk_rd("rr_b0", 8'h57, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_rd("rr_b1", 8'h34, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rd("rr_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk_acc("rr_rst", 24'h0, 8'd0, 1'b0);
    tick();
    chk_rd("rr_nob2", 8'h00, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk_rd("z_b0", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rd("z_b1", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rd("z_b2", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    chk_rd("z_done", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
